// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: two-master, one-slave arbiter for the AXI-lite read channel (AR + R)
// of the shared instruction/data SRAM. Master 0 is the IFU fetch port, master 1 is the
// LSU load port, the slave port drives the axi_sram read interface.
//
// Only one transaction is outstanding at a time. A grant is registered in IDLE and held
// through ADDR and DATA until the R handshake completes. Each transaction costs at least
// three cycles (IDLE arbitration, ADDR, DATA).
//
// Optional feature macro: ARB_LSU_PRIORITY_EN
//   defined   - fixed priority, master 1 (LSU) wins simultaneous requests, rr held at 0
//   undefined - round-robin between the two masters
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   m0_* / m1_*          AR + R channels of the IFU / LSU master ports
//   s_*                  AR + R channels of the slave port
//   busy                 high whenever the arbiter is not idle
module axi_rd_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // Master 0 (IFU)
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  // Master 1 (LSU)
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  // Slave
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready,
  // Status
  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   g_q, g_d;
  logic   rr_q, rr_d;
  logic   winner;
  logic   sel_arvalid;
  logic   sel_rready;

  // Winner of IDLE arbitration. A sole requester always wins; with no request the value
  // is irrelevant because the FSM stays idle.
`ifdef ARB_LSU_PRIORITY_EN
  assign winner = m1_arvalid;
`else
  assign winner = (m0_arvalid && m1_arvalid) ? rr_q : m1_arvalid;
`endif

  // Signals of the currently granted master.
  assign sel_arvalid = g_q ? m1_arvalid : m0_arvalid;
  assign sel_rready  = g_q ? m1_rready  : m0_rready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      g_q     <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    rr_d       = rr_q;

    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = 2'b00;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = 2'b00;
    m1_rvalid  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // All outputs stay 0 here; a stray s_rvalid is not acknowledged.
        if (m0_arvalid || m1_arvalid) begin
          g_d     = winner;
          state_d = StAddr;
        end
      end

      StAddr: begin
        s_arvalid = sel_arvalid;
        if (g_q) begin
          s_araddr   = m1_araddr;
          m1_arready = s_arready;
        end else begin
          s_araddr   = m0_araddr;
          m0_arready = s_arready;
        end
        if (sel_arvalid && s_arready) begin
          state_d = StData;
        end else if (!sel_arvalid) begin
          // Master withdrew its request before the handshake: abandon without a transfer.
          state_d = StIdle;
        end
      end

      StData: begin
        s_rready = sel_rready;
        if (g_q) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
        end
        if (s_rvalid && sel_rready) begin
          state_d = StIdle;
`ifdef ARB_LSU_PRIORITY_EN
          rr_d    = 1'b0;
`else
          // Favour the other master on the next simultaneous request.
          rr_d    = ~g_q;
`endif
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy = (state_q != StIdle);

endmodule
